// File: rtl/orb_desc_seq.sv
// orb_desc_seq -- ORB descriptor sequencer.
//
// A feature is accepted in IDLE. The sequencer waits SECTOR_LATENCY cycles for
// the orientation sector, then issues NUM_COMPARISONS/BITS_PER_CLOCK sample-pair
// indices to the external pattern/rotate/window datapath. The returned pixel
// comparisons are assembled into a descriptor. Finished descriptors are queued
// with their coordinates in a FIFO_DEPTH-entry FIFO with valid/ready handshake.
//
// Ports:
//   clk, in_reset            clock, synchronous active-high reset
//   in_go, in_x, in_y        start request and feature coordinates
//   in_window_ready          patch window full
//   in_moment_zero           orientation undefined, so the request is refused
//   in_sector                orientation sector, latched in the last SECTOR cycle
//   in_threshold             comparison margin
//   in_pix1, in_pix2         returned pixel pairs, one LUMA_BITS field per lane
//   out_accepting_input      high in IDLE
//   out_mode                 window input mode (IDLE or reset)
//   out_sector               latched sector for the rotation LUT
//   out_sample_valid/index   index issue strobe and first bit index of the group
//   out_valid/ready          FIFO head handshake
//   out_descriptor, out_feature_x/y   FIFO head (0 when empty)
//   out_stat_emitted/skipped statistics
//
// Optional feature macro: ORB_DESC_STATS_EN enables the statistics counters.
// When the macro is not defined, the statistics ports read 0.
module orb_desc_seq #(
   parameter int LUMA_BITS       = 8,
   parameter int COORD_BITS      = 10,
   parameter int NUM_COMPARISONS = 256,
   parameter int BITS_PER_CLOCK  = 1,
   parameter int ANGLE_BITS      = 5,
   parameter int SECTOR_LATENCY  = 6,
   parameter int SAMPLE_LATENCY  = 3,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                                 clk,
   input  logic                                 in_reset,
   input  logic                                 in_go,
   input  logic [COORD_BITS-1:0]                in_x,
   input  logic [COORD_BITS-1:0]                in_y,
   input  logic                                 in_window_ready,
   input  logic                                 in_moment_zero,
   input  logic [ANGLE_BITS-1:0]                in_sector,
   input  logic [LUMA_BITS-1:0]                 in_threshold,
   input  logic [LUMA_BITS*BITS_PER_CLOCK-1:0]  in_pix1,
   input  logic [LUMA_BITS*BITS_PER_CLOCK-1:0]  in_pix2,
   output logic                                 out_accepting_input,
   output logic                                 out_mode,
   output logic [ANGLE_BITS-1:0]                out_sector,
   output logic                                 out_sample_valid,
   output logic [$clog2(NUM_COMPARISONS)-1:0]   out_sample_index,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [NUM_COMPARISONS-1:0]           out_descriptor,
   output logic [COORD_BITS-1:0]                out_feature_x,
   output logic [COORD_BITS-1:0]                out_feature_y,
   output logic [15:0]                          out_stat_emitted,
   output logic [15:0]                          out_stat_skipped
);

   localparam int NG = NUM_COMPARISONS / BITS_PER_CLOCK;
   localparam int IW = $clog2(NUM_COMPARISONS);
   localparam int LB = $clog2(BITS_PER_CLOCK);
   localparam int CW = $clog2(NG + SECTOR_LATENCY + SAMPLE_LATENCY + 1);
   localparam int GW = (NG > 1) ? $clog2(NG) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int KW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = NUM_COMPARISONS + 2 * COORD_BITS;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SECTOR = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   // The sum is formed one bit wider than a pixel, so pix1 + threshold never wraps.
   function automatic logic lane_cmp(input logic [LUMA_BITS-1:0] p1,
                                     input logic [LUMA_BITS-1:0] p2,
                                     input logic [LUMA_BITS-1:0] thr);
      return ({1'b0, p1} + {1'b0, thr}) < {1'b0, p2};
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ANGLE_BITS-1:0] sector_q, sector_d;
   logic                  sample_valid_q, sample_valid_d;
   logic [IW-1:0]         sample_index_q, sample_index_d;
   logic [SAMPLE_LATENCY-1:0] vpipe_q;
   logic [GW-1:0]         cap_q, cap_d;
   logic [NUM_COMPARISONS-1:0] desc_q, desc_d;
   logic [COORD_BITS-1:0] x_q, y_q;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic [PW-1:0]         rd_q, wr_q;
   logic [KW-1:0]         count_q;
   logic [EW-1:0]         head_s;
   logic                  fifo_full_s, fifo_empty_s, go_ok_s, push_s, pop_s;

   assign fifo_full_s  = (count_q == KW'(FIFO_DEPTH));
   assign fifo_empty_s = (count_q == '0);
   assign go_ok_s      = (state_q == ST_IDLE) && in_go && in_window_ready &&
                         !in_moment_zero && !fifo_full_s;
   assign pop_s        = !fifo_empty_s && out_ready;

   // Sequencer next state, sector latch and index-issue outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sector_d = sector_q;
      case (state_q)
         ST_IDLE: begin
            if (go_ok_s) begin
               state_d = ST_SECTOR;
               cnt_d   = '0;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_SECTOR: begin
            if (cnt_q == CW'(SECTOR_LATENCY - 1)) begin
               state_d  = ST_ISSUE;
               cnt_d    = '0;
               sector_d = in_sector;
            end else begin
               cnt_d    = cnt_q + CW'(1);
            end
         end
         ST_ISSUE: begin
            if (cnt_q == CW'(NG - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == CW'(SAMPLE_LATENCY - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Registered so the index appears in the same cycle as the strobe.
      sample_valid_d = (state_d == ST_ISSUE);
      if (sample_valid_d) begin
         sample_index_d = IW'(cnt_d) << LB;
      end else begin
         sample_index_d = '0;
      end
   end

   // Capture of the returned comparison groups into the descriptor.
   always_comb begin
      desc_d = desc_q;
      cap_d  = cap_q;
      push_s = 1'b0;
      if (vpipe_q[SAMPLE_LATENCY-1]) begin
         for (int i = 0; i < BITS_PER_CLOCK; i++) begin
            desc_d[int'(cap_q) * BITS_PER_CLOCK + i] =
               lane_cmp(in_pix1[i*LUMA_BITS +: LUMA_BITS],
                        in_pix2[i*LUMA_BITS +: LUMA_BITS], in_threshold);
         end
         if (cap_q == GW'(NG - 1)) begin
            push_s = 1'b1;
            cap_d  = '0;
         end else begin
            cap_d  = cap_q + GW'(1);
         end
      end else begin
         cap_d = cap_q;
      end
   end

   // Control state, valid pipeline, capture state and FIFO pointers.
   always_ff @(posedge clk) begin
      if (in_reset) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         sector_q       <= '0;
         sample_valid_q <= 1'b0;
         sample_index_q <= '0;
         vpipe_q        <= '0;
         cap_q          <= '0;
         desc_q         <= '0;
         x_q            <= '0;
         y_q            <= '0;
         rd_q           <= '0;
         wr_q           <= '0;
         count_q        <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         sector_q       <= sector_d;
         sample_valid_q <= sample_valid_d;
         sample_index_q <= sample_index_d;
         // Bit 0 is the newest issue; the top bit tags data returning this cycle.
         vpipe_q        <= SAMPLE_LATENCY'({vpipe_q, sample_valid_q});
         cap_q          <= cap_d;
         desc_q         <= desc_d;
         if (go_ok_s) begin
            x_q <= in_x;
            y_q <= in_y;
         end
         if (push_s) begin
            wr_q <= ptr_inc(wr_q);
         end
         if (pop_s) begin
            rd_q <= ptr_inc(rd_q);
         end
         count_q <= count_q + KW'(push_s) - KW'(pop_s);
      end
   end

   // FIFO storage; contents are qualified by count, so they need no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_q] <= {desc_d, x_q, y_q};
      end
   end

   assign head_s              = mem_q[rd_q];
   assign out_valid           = !fifo_empty_s;
   assign out_descriptor      = fifo_empty_s ? '0 : head_s[EW-1 -: NUM_COMPARISONS];
   assign out_feature_x       = fifo_empty_s ? '0 : head_s[2*COORD_BITS-1 -: COORD_BITS];
   assign out_feature_y       = fifo_empty_s ? '0 : head_s[COORD_BITS-1:0];
   assign out_accepting_input = (state_q == ST_IDLE);
   assign out_mode            = (state_q == ST_IDLE) || in_reset;
   assign out_sector          = sector_q;
   assign out_sample_valid    = sample_valid_q;
   assign out_sample_index    = sample_index_q;

`ifdef ORB_DESC_STATS_EN
   logic [15:0] emit_q, skip_q;
   logic        skip_s;

   assign skip_s = (state_q == ST_IDLE) && in_go && in_window_ready &&
                   (in_moment_zero || fifo_full_s);

   // Saturating counters of popped descriptors and refused requests.
   always_ff @(posedge clk) begin
      if (in_reset) begin
         emit_q <= 16'd0;
         skip_q <= 16'd0;
      end else begin
         if (pop_s && (emit_q != 16'hFFFF)) begin
            emit_q <= emit_q + 16'd1;
         end
         if (skip_s && (skip_q != 16'hFFFF)) begin
            skip_q <= skip_q + 16'd1;
         end
      end
   end

   assign out_stat_emitted = emit_q;
   assign out_stat_skipped = skip_q;
`else
   assign out_stat_emitted = 16'd0;
   assign out_stat_skipped = 16'd0;
`endif

endmodule

// File: tb/tb_orb_desc_seq.sv
// Testbench for orb_desc_seq: a default instance (1 lane) and a 4-lane instance
// share the control inputs. A responder returns pixel pairs SAMPLE_LATENCY
// cycles after each issued index and records them. The expected descriptor is
// recomputed from the recorded pixels with plain integer arithmetic.
module tb_orb_desc_seq;

`ifdef ORB_DESC_STATS_EN
   localparam int STATS_ON = 1;
`else
   localparam int STATS_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        in_reset, in_go, in_window_ready, in_moment_zero;
   logic [9:0]  in_x, in_y;
   logic [4:0]  in_sector;
   logic [7:0]  in_threshold;
   logic [7:0]  p1_0, p2_0;
   logic [31:0] p1_4, p2_4;
   logic        ready0, ready4;
   logic        acc0, acc4, mode0, mode4, sv0, sv4, ov0, ov4;
   logic [4:0]  sec0, sec4;
   logic [7:0]  si0, si4;
   logic [255:0] d0, d4;
   logic [9:0]  fx0, fy0, fx4, fy4;
   logic [15:0] se0, sk0, se4, sk4;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [255:0] d;
      logic [9:0]   x;
      logic [9:0]   y;
   } ent_t;
   ent_t q0[$];

   // responder state: pixel pattern mode, recorded pixels, issue history
   int         pmode = 0;
   logic [7:0] pa = 8'd0, pb = 8'd0;
   logic [7:0] rp1 [2][256];
   logic [7:0] rp2 [2][256];
   logic       hv [2][3];
   logic [7:0] hi [2][3];

   always #5 clk = ~clk;

   orb_desc_seq dut (
      .clk(clk), .in_reset(in_reset), .in_go(in_go), .in_x(in_x), .in_y(in_y),
      .in_window_ready(in_window_ready), .in_moment_zero(in_moment_zero),
      .in_sector(in_sector), .in_threshold(in_threshold), .in_pix1(p1_0), .in_pix2(p2_0),
      .out_accepting_input(acc0), .out_mode(mode0), .out_sector(sec0),
      .out_sample_valid(sv0), .out_sample_index(si0), .out_valid(ov0), .out_ready(ready0),
      .out_descriptor(d0), .out_feature_x(fx0), .out_feature_y(fy0),
      .out_stat_emitted(se0), .out_stat_skipped(sk0));

   orb_desc_seq #(.BITS_PER_CLOCK(4)) dut4 (
      .clk(clk), .in_reset(in_reset), .in_go(in_go), .in_x(in_x), .in_y(in_y),
      .in_window_ready(in_window_ready), .in_moment_zero(in_moment_zero),
      .in_sector(in_sector), .in_threshold(in_threshold), .in_pix1(p1_4), .in_pix2(p2_4),
      .out_accepting_input(acc4), .out_mode(mode4), .out_sector(sec4),
      .out_sample_valid(sv4), .out_sample_index(si4), .out_valid(ov4), .out_ready(ready4),
      .out_descriptor(d4), .out_feature_x(fx4), .out_feature_y(fy4),
      .out_stat_emitted(se4), .out_stat_skipped(sk4));

   function automatic logic [15:0] gen_pix(input logic [7:0] idx);
      case (pmode)
         0:       return {idx, 8'd128};
         1:       return {pa, pb};
         default: return {8'($urandom), 8'($urandom)};
      endcase
   endfunction

   // Reference: bit b = pix1[b] + threshold < pix2[b], evaluated as integers.
   function automatic logic [255:0] model_desc(input int s, input int thr);
      logic [255:0] m;
      for (int b = 0; b < 256; b++) begin
         m[b] = ((int'(rp1[s][b]) + thr) < int'(rp2[s][b]));
      end
      return m;
   endfunction

   initial begin
      for (int s = 0; s < 2; s++) begin
         for (int j = 0; j < 3; j++) begin
            hv[s][j] = 1'b0;
            hi[s][j] = 8'd0;
         end
      end
   end

   // Pixel responder: returns data 3 cycles after each index issue.
   always @(negedge clk) begin
      logic [15:0] pp;
      for (int l = 0; l < 4; l++) begin
         pp = gen_pix(hi[1][2] + 8'(l));
         p1_4[l*8 +: 8] = pp[15:8];
         p2_4[l*8 +: 8] = pp[7:0];
         if (hv[1][2]) begin
            rp1[1][int'(hi[1][2]) + l] = pp[15:8];
            rp2[1][int'(hi[1][2]) + l] = pp[7:0];
         end
      end
      pp = gen_pix(hi[0][2]);
      p1_0 = pp[15:8];
      p2_0 = pp[7:0];
      if (hv[0][2]) begin
         rp1[0][hi[0][2]] = pp[15:8];
         rp2[0][hi[0][2]] = pp[7:0];
      end
      for (int j = 2; j > 0; j--) begin
         hv[0][j] = hv[0][j-1];
         hi[0][j] = hi[0][j-1];
         hv[1][j] = hv[1][j-1];
         hi[1][j] = hi[1][j-1];
      end
      hv[0][0] = sv0;
      hi[0][0] = si0;
      hv[1][0] = sv4;
      hi[1][0] = si4;
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Continues a feature whose go is accepted at the coming edge.
   task automatic finish_feature(input int s, input logic [9:0] fx, input logic [9:0] fy);
      int         lat = 0;
      int         issues = 0;
      logic       idx_bad = 1'b0;
      logic [4:0] sec = 5'($urandom);
      int         n = (s == 1) ? 64 : 256;
      int         bpc = (s == 1) ? 4 : 1;
      ent_t       e;
      for (int c = 1; c <= 2000 && lat == 0; c++) begin
         @(negedge clk);
         in_go     = 1'b0;
         in_sector = (c == 6) ? sec : ~sec;
         if ((s == 1) ? sv4 : sv0) begin
            if (((s == 1) ? si4 : si0) != 8'(issues * bpc)) idx_bad = 1'b1;
            issues++;
         end
         if (c == 7) chk("sector_latch", (s == 1) ? sec4 : sec0, sec);
         if ((s == 1) ? acc4 : acc0) lat = c;
      end
      chk("latency", lat, (s == 1) ? 74 : 266);
      chk("issue_count", issues, n);
      chk("index_seq", idx_bad, 0);
      chk("valid_up", (s == 1) ? ov4 : ov0, 1);
      e.d = model_desc(s, int'(in_threshold));
      e.x = fx;
      e.y = fy;
      if (s == 1) begin
         chk("desc4", d4, e.d);
         chk("x4", fx4, fx);
         chk("y4", fy4, fy);
      end else begin
         q0.push_back(e);
      end
   endtask

   task automatic run_feature(input int s);
      logic [9:0] fx = 10'($urandom);
      logic [9:0] fy = 10'($urandom);
      in_x  = fx;
      in_y  = fy;
      in_go = 1'b1;
      finish_feature(s, fx, fy);
   endtask

   task automatic check_head0(input string tag);
      chk({tag, "_valid"}, ov0, 1);
      chk({tag, "_desc"}, d0, q0[0].d);
      chk({tag, "_x"}, fx0, q0[0].x);
      chk({tag, "_y"}, fy0, q0[0].y);
   endtask

   task automatic pop0();
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      void'(q0.pop_front());
   endtask

   task automatic wait_idle();
      int ok = 0;
      for (int c = 0; c < 1000 && ok == 0; c++) begin
         @(negedge clk);
         if (acc0 && acc4) ok = 1;
      end
      chk("idle_wait", ok, 1);
   endtask

   initial begin
      logic [255:0] half;
      logic         seen;
      logic         hold_ok;
      logic [9:0]   cx, cy;
      half = {{128{1'b0}}, {128{1'b1}}};
      in_reset = 1'b1; in_go = 1'b0; in_window_ready = 1'b1; in_moment_zero = 1'b0;
      in_x = 10'd0; in_y = 10'd0; in_sector = 5'd0; in_threshold = 8'd0;
      ready0 = 1'b0; ready4 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_mode_in_reset", mode0, 1);
      in_reset = 1'b0;
      @(negedge clk);
      chk("rst_valid", ov0, 0);
      chk("rst_sample_valid", sv0, 0);
      chk("rst_accepting", acc0, 1);
      chk("rst_mode", mode0, 1);
      chk("rst_index", si0, 0);
      chk("rst_desc", d0, 0);
      chk("rst_xy", {fx0, fy0}, 0);
      chk("rst_sector", sec0, 0);
      chk("rst_stats", {se0, sk0}, 0);

      // pattern pix1=index, pix2=128, threshold 0
      pmode = 0; in_threshold = 8'd0;
      run_feature(0);
      check_head0("t1");
      chk("t1_half", d0, half);
      pop0();
      chk("t1_empty_valid", ov0, 0);
      chk("t1_empty_desc", {d0, fx0, fy0}, 0);
      chk("stat_emitted", se0, STATS_ON);

      // moment zero: request refused
      in_go = 1'b1; in_moment_zero = 1'b1;
      @(negedge clk);
      in_go = 1'b0; in_moment_zero = 1'b0;
      seen = 1'b0; hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (sv0) seen = 1'b1;
         if (!acc0) hold_ok = 1'b0;
      end
      chk("mz_no_issue", seen, 0);
      chk("mz_idle", hold_ok, 1);
      chk("stat_skipped", sk0, STATS_ON);

      // threshold edge cases
      pmode = 1; pa = 8'd100; pb = 8'd110; in_threshold = 8'd10;
      run_feature(0); check_head0("thr10"); chk("thr10_zero", d0, 0); pop0();
      in_threshold = 8'd9;
      run_feature(0); check_head0("thr9"); chk("thr9_ones", d0, {256{1'b1}}); pop0();
      pa = 8'd255; pb = 8'd255; in_threshold = 8'd255;
      run_feature(0); check_head0("nowrap"); chk("nowrap_zero", d0, 0); pop0();
      pmode = 2;
      for (int r = 0; r < 2; r++) begin
         in_threshold = 8'($urandom_range(0, 80));
         run_feature(0); check_head0("rand"); pop0();
      end

      // backpressure: two queued, further go refused
      in_threshold = 8'($urandom_range(0, 60));
      run_feature(0);
      run_feature(0);
      cx = 10'($urandom); cy = 10'($urandom);
      in_x = cx; in_y = cy; in_go = 1'b1;
      seen = 1'b0; hold_ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (sv0) seen = 1'b1;
         if (!acc0 || !ov0) hold_ok = 1'b0;
      end
      chk("bp_no_issue", seen, 0);
      chk("bp_hold", hold_ok, 1);
      check_head0("bp_a");
      ready0 = 1'b1;
      @(negedge clk);
      ready0 = 1'b0;
      void'(q0.pop_front());
      chk("bp_acc_after_pop", acc0, 1);
      check_head0("bp_b");
      finish_feature(0, cx, cy);
      check_head0("bp_b2");
      pop0();
      check_head0("bp_c");
      pop0();
      chk("bp_drained", ov0, 0);

      // four lanes
      wait_idle();
      in_threshold = 8'($urandom_range(0, 80));
      run_feature(1);
      pmode = 0; in_threshold = 8'd0;
      run_feature(1);
      chk("lane_order_half", d4, half);
      wait_idle();
      ready0 = 1'b1;
      repeat (2) @(negedge clk);
      ready0 = 1'b0;
      chk("drain_main", ov0, 0);

      // reset in the middle of ISSUE
      pmode = 2;
      in_x = 10'($urandom); in_y = 10'($urandom); in_go = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         in_go = 1'b0;
      end
      in_reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_sample_valid", sv0, 0);
      chk("mid_rst_accepting", acc0, 1);
      chk("mid_rst_valid", ov0, 0);
      chk("mid_rst_mode", mode0, 1);
      in_reset = 1'b0;
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (ov0 || sv0) seen = 1'b1;
      end
      chk("aborted_no_output", seen, 0);
      chk("mid_rst_stats", {se0, sk0}, 0);
      in_threshold = 8'($urandom_range(0, 80));
      run_feature(0); check_head0("post_rst"); pop0();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/orb_desc_seq.md
# orb_desc_seq

Parametrised ORB descriptor sequencer: the next-generation control/assembly core for the feature-descriptor path. It accepts a feature start request and waits a fixed latency for the orientation sector. It then issues NUM_COMPARISONS/BITS_PER_CLOCK sample-pair indices to the external pattern ROM / vector-rotate / window datapath and assembles the returned pixel comparisons into a descriptor. Finished descriptors are queued, with feature coordinates, in a FIFO with valid/ready backpressure. New over the previous generation: configurable lanes and latencies, a runtime comparison threshold, output buffering with backpressure, and optional statistics counters.

## Interface
- LUMA_BITS, 8, pixel width
- COORD_BITS, 10, image-space coordinate width
- NUM_COMPARISONS, 256, descriptor length; multiple of BITS_PER_CLOCK
- BITS_PER_CLOCK, 1, comparison lanes per cycle; power of two
- ANGLE_BITS, 5, sector index width
- SECTOR_LATENCY, 6, cycles from accepted go to valid in_sector (≥1)
- SAMPLE_LATENCY, 3, cycles from index issue to matching in_pix (≥1)
- FIFO_DEPTH, 2, output descriptor slots (≥1)

Ports:
- clk  in  1  clock; all logic on posedge
- in_reset  in  1  synchronous, active-high reset
- in_go  in  1  start request for current feature
- in_x, in_y  in  COORD_BITS  feature coordinates, sampled with accepted go
- in_window_ready  in  1  patch window full
- in_moment_zero  in  1  both moments zero (angle undefined)
- in_sector  in  ANGLE_BITS  orientation sector from sector selector
- in_threshold  in  LUMA_BITS  comparison margin
- in_pix1, in_pix2  in  LUMA_BITS×BITS_PER_CLOCK  sampled pixel pairs
- out_accepting_input  out  1  state==IDLE
- out_mode  out  1  window input mode: state==IDLE || in_reset
- out_sector  out  ANGLE_BITS  latched sector for rotation LUT
- out_sample_valid  out  1  index issue strobe
- out_sample_index  out  $clog2(NUM_COMPARISONS)  first bit index of the issued group
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- out_descriptor  out  NUM_COMPARISONS  head descriptor
- out_feature_x, out_feature_y  out  COORD_BITS  head coordinates
- out_stat_emitted, out_stat_skipped  out  16  statistics (see Configuration)

## Operation
- States: IDLE → SECTOR (SECTOR_LATENCY cycles) → ISSUE (N = NUM_COMPARISONS/BITS_PER_CLOCK cycles) → DRAIN (SAMPLE_LATENCY cycles) → IDLE.
- Go is accepted in IDLE when in_go && in_window_ready && !in_moment_zero && fifo_count < FIFO_DEPTH. On acceptance, latch in_x/in_y.
- Last SECTOR cycle: latch in_sector into out_sector. It holds until the next latch.
- ISSUE cycle k (0..N-1): out_sample_valid=1, out_sample_index=k·BITS_PER_CLOCK.
- A SAMPLE_LATENCY-deep valid pipeline tags the returning data. For returned group k, lane i sets descriptor bit k·BITS_PER_CLOCK+i = ({1'b0,in_pix1[i]} + in_threshold) < {1'b0,in_pix2[i]}, evaluated at LUMA_BITS+1 width with no wrap.
- Capture of the last group pushes {descriptor, x, y} into the FIFO. Room is guaranteed by the acceptance rule, because only one descriptor is ever in flight.
- FIFO: pop on out_valid && out_ready. Simultaneous push and pop is legal, with count unchanged. When empty, out_descriptor, out_feature_x and out_feature_y read 0.
- in_go outside IDLE is ignored.
- Reset: state IDLE, FIFO flushed, valid pipeline cleared (in-flight pixels discarded), out_sector 0, stats 0.
- Reset values of outputs: out_valid 0, out_sample_valid 0, out_accepting_input 1, out_mode 1, out_sample_index 0, data outputs 0.

## Timing
- Go accepted at edge E0. SECTOR occupies cycles 1..S, ISSUE occupies S+1..S+N, DRAIN occupies S+N+1..S+N+L. The last group is captured at the end of cycle S+N+L.
- out_valid rises in cycle S+N+L+1 (FIFO previously empty). out_accepting_input also rises in that cycle.
- Defaults (S=6, N=256, L=3): out_valid at cycle 266. With BITS_PER_CLOCK=4: cycle 74.
- out_sample_index is registered and coincides with out_sample_valid.
- The FIFO head is registered. Pop takes effect at the edge, and the next entry is visible in the following cycle.

## Configuration
- ORB_DESC_STATS_EN defined: out_stat_emitted increments on each pop. out_stat_skipped increments on each IDLE cycle with in_go && in_window_ready && (in_moment_zero || FIFO full). Both saturate at 16'hFFFF and are cleared by reset.
- ORB_DESC_STATS_EN undefined: the ports remain and are tied to 0. No counter logic is present.

## Test plan
- Defaults, threshold 0. Bench drives in_pix1 = (issued index)[7:0] and in_pix2=128, each delayed by 3 cycles. One go → out_valid at cycle 266; descriptor[127:0] all 1, [255:128] all 0; coordinates match the go cycle.
- in_moment_zero=1 with go and window ready → out_sample_valid never asserts and state stays IDLE. With stats enabled, out_stat_skipped=1.
- Threshold: pix1=100, pix2=110. in_threshold=10 → descriptor all 0. in_threshold=9 → all 1. pix1=255, threshold=255 → 0 (no wrap).
- Backpressure: FIFO_DEPTH=2, out_ready=0, go held high → two descriptors queued, further go refused, out_accepting_input stays 1. Pulse out_ready once → next go accepted the following cycle. Heads pop in order.
- BITS_PER_CLOCK=4 → 64 issue cycles with indices 0,4,…,252; out_valid at cycle 74; bit order per lane rule.
- in_reset at cycle 100 (mid-ISSUE) → next cycle out_sample_valid=0, out_accepting_input=1, out_valid=0. No descriptor emerges from the aborted feature. A following go completes normally.
